l1_mem_router: RTL and testbench



---
 rtl/l1_mem_router.sv | 160 ++++++++++++++++
 tb/tb_l1_mem_router.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_router.sv
// Address router behind the L1 arbiter: steers one master stream to RAM (s0), IO (s1) or an
// internal error responder, keeping read responses in request order.
module l1_mem_router #(
   parameter logic [31:0] S0_BASE        = 32'h0000_0000,
   parameter logic [31:0] S0_MASK        = 32'hFFFF_0000,
   parameter logic [31:0] S1_BASE        = 32'h8000_0000,
   parameter logic [31:0] S1_MASK        = 32'hFFFF_F000,
   parameter int          MAX_OUTST      = 4,
   parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // upstream master
   input  logic        i_m_req,
   input  logic        i_m_we,
   input  logic [31:0] i_m_addr,
   input  logic [3:0]  i_m_be,
   input  logic [31:0] i_m_wdata,
   output logic        o_m_ack,
   output logic        o_m_resp,
   output logic [31:0] o_m_rdata,
   // RAM slave
   output logic        o_s0_req,
   output logic        o_s0_we,
   output logic [31:0] o_s0_addr,
   output logic [3:0]  o_s0_be,
   output logic [31:0] o_s0_wdata,
   input  logic        i_s0_ack,
   input  logic        i_s0_resp,
   input  logic [31:0] i_s0_rdata,
   // IO slave
   output logic        o_s1_req,
   output logic        o_s1_we,
   output logic [31:0] o_s1_addr,
   output logic [3:0]  o_s1_be,
   output logic [31:0] o_s1_wdata,
   input  logic        i_s1_ack,
   input  logic        i_s1_resp,
   input  logic [31:0] i_s1_rdata
);

   typedef enum logic [1:0] {
      TGT_S0  = 2'd0,
      TGT_S1  = 2'd1,
      TGT_ERR = 2'd2
   } tgt_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

   tgt_t       r_tgt, w_tgt_next, w_sel;
   logic [3:0] r_cnt, w_cnt_next;
   logic       r_err_resp, w_err_resp_next;
   logic       w_fwd, w_go, w_rd_acc, w_rsp;

   // S0 has priority when both windows match.
   always_comb begin
      w_sel = TGT_ERR;
      if ((i_m_addr & S0_MASK) == S0_BASE)
         w_sel = TGT_S0;
      else if ((i_m_addr & S1_MASK) == S1_BASE)
         w_sel = TGT_S1;
   end

   assign w_fwd = (r_cnt == 4'd0) || ((w_sel == r_tgt) && (i_m_we || (r_cnt < MAX_CNT)));
   assign w_go  = rst_i && i_m_req && w_fwd;

   always_comb begin
      o_m_ack    = 1'b0;
      o_s0_req   = 1'b0;
      o_s0_we    = 1'b0;
      o_s0_addr  = '0;
      o_s0_be    = '0;
      o_s0_wdata = '0;
      o_s1_req   = 1'b0;
      o_s1_we    = 1'b0;
      o_s1_addr  = '0;
      o_s1_be    = '0;
      o_s1_wdata = '0;
      if (w_go) begin
         case (w_sel)
            TGT_S0: begin
               o_s0_req   = 1'b1;
               o_s0_we    = i_m_we;
               o_s0_addr  = i_m_addr;
               o_s0_be    = i_m_be;
               o_s0_wdata = i_m_wdata;
               o_m_ack    = i_s0_ack;
            end
            TGT_S1: begin
               o_s1_req   = 1'b1;
               o_s1_we    = i_m_we;
               o_s1_addr  = i_m_addr;
               o_s1_be    = i_m_be;
               o_s1_wdata = i_m_wdata;
               o_m_ack    = i_s1_ack;
            end
            default: o_m_ack = 1'b1;
         endcase
      end
   end

   always_comb begin
      o_m_resp  = 1'b0;
      o_m_rdata = '0;
      if (rst_i && (r_cnt != 4'd0)) begin
         case (r_tgt)
            TGT_S0: begin
               o_m_resp  = i_s0_resp;
               o_m_rdata = i_s0_rdata;
            end
            TGT_S1: begin
               o_m_resp  = i_s1_resp;
               o_m_rdata = i_s1_rdata;
            end
            default: begin
               o_m_resp  = r_err_resp;
               o_m_rdata = UNMAPPED_RDATA;
            end
         endcase
      end
   end

   assign w_rd_acc = i_m_req && !i_m_we && o_m_ack;
   assign w_rsp    = o_m_resp;

   always_comb begin
      w_tgt_next      = r_tgt;
      w_cnt_next      = r_cnt;
      w_err_resp_next = w_rd_acc && (w_sel == TGT_ERR);
      if (w_rd_acc)
         w_tgt_next = w_sel;
      if (w_rd_acc && !w_rsp)
         w_cnt_next = r_cnt + 4'd1;
      else if (w_rsp && !w_rd_acc)
         w_cnt_next = r_cnt - 4'd1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_tgt      <= TGT_S0;
         r_cnt      <= 4'd0;
         r_err_resp <= 1'b0;
      end else begin
         r_tgt      <= w_tgt_next;
         r_cnt      <= w_cnt_next;
         r_err_resp <= w_err_resp_next;
      end
   end

   // A slave answering while reads are owed to the other target is a protocol error.
   a_s0_stray: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(i_s0_resp && (r_cnt != 4'd0) && (r_tgt != TGT_S0)));
   a_s1_stray: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(i_s1_resp && (r_cnt != 4'd0) && (r_tgt != TGT_S1)));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(w_rsp && (r_cnt == 4'd0)));
   a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
      r_cnt <= MAX_CNT);

endmodule

// File: tb/tb_l1_mem_router.sv
// Directed bench for l1_mem_router: a queue-based model of outstanding reads is checked every
// cycle, alongside literal expectations taken from hand-worked scenarios.
module tb_l1_mem_router;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   logic        m_ack, m_resp;
   logic [31:0] m_rdata;
   logic        s0_req, s0_we, s0_ack, s0_resp;
   logic [31:0] s0_addr, s0_wdata, s0_rdata;
   logic [3:0]  s0_be;
   logic        s1_req, s1_we, s1_ack, s1_resp;
   logic [31:0] s1_addr, s1_wdata, s1_rdata;
   logic [3:0]  s1_be;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   l1_mem_router dut (
      .clk_i(clk), .rst_i(rst_i),
      .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_be(m_be), .i_m_wdata(m_wdata),
      .o_m_ack(m_ack), .o_m_resp(m_resp), .o_m_rdata(m_rdata),
      .o_s0_req(s0_req), .o_s0_we(s0_we), .o_s0_addr(s0_addr), .o_s0_be(s0_be),
      .o_s0_wdata(s0_wdata), .i_s0_ack(s0_ack), .i_s0_resp(s0_resp), .i_s0_rdata(s0_rdata),
      .o_s1_req(s1_req), .o_s1_we(s1_we), .o_s1_addr(s1_addr), .o_s1_be(s1_be),
      .o_s1_wdata(s1_wdata), .i_s1_ack(s1_ack), .i_s1_resp(s1_resp), .i_s1_rdata(s1_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // 0 = RAM, 1 = IO, 2 = unmapped
   function automatic int decode(input logic [31:0] a);
      if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
      if ((a & 32'hFFFF_F000) == 32'h8000_0000) return 1;
      return 2;
   endfunction

   // Model: queue of the destinations of reads still owed a response, oldest first.
   int q_dst[$];
   bit err_due;

   always @(negedge clk) begin
      int          sel;
      bit          go;
      logic        e_ack, e_resp;
      logic [31:0] e_rdata;
      logic [5:0]  e_c0, e_c1;
      logic [31:0] e_a0, e_a1, e_w0, e_w1;
      sel = decode(m_addr);
      e_ack = 0; e_resp = 0; e_rdata = 0;
      e_c0 = 0; e_c1 = 0; e_a0 = 0; e_a1 = 0; e_w0 = 0; e_w1 = 0;
      if (!rst_i) begin
         q_dst.delete();
         err_due = 0;
      end else begin
         go = m_req && (q_dst.size() == 0 ||
                        (sel == q_dst[0] && (m_we || q_dst.size() < 4)));
         if (go) begin
            if (sel == 0) begin
               e_c0 = {1'b1, m_we, m_be}; e_a0 = m_addr; e_w0 = m_wdata; e_ack = s0_ack;
            end else if (sel == 1) begin
               e_c1 = {1'b1, m_we, m_be}; e_a1 = m_addr; e_w1 = m_wdata; e_ack = s1_ack;
            end else begin
               e_ack = 1;
            end
         end
         if (q_dst.size() > 0) begin
            if (q_dst[0] == 0) begin e_resp = s0_resp; e_rdata = s0_rdata; end
            else if (q_dst[0] == 1) begin e_resp = s1_resp; e_rdata = s1_rdata; end
            else begin e_resp = err_due; e_rdata = 32'hDEAD_BEEF; end
         end
      end
      chk("m_ack",    32'(m_ack),  32'(e_ack));
      chk("m_resp",   32'(m_resp), 32'(e_resp));
      chk("m_rdata",  m_rdata,     e_rdata);
      chk("s0_ctl",   32'({s0_req, s0_we, s0_be}), 32'(e_c0));
      chk("s0_addr",  s0_addr,  e_a0);
      chk("s0_wdata", s0_wdata, e_w0);
      chk("s1_ctl",   32'({s1_req, s1_we, s1_be}), 32'(e_c1));
      chk("s1_addr",  s1_addr,  e_a1);
      chk("s1_wdata", s1_wdata, e_w1);
      if (rst_i) begin
         if (e_resp) void'(q_dst.pop_front());
         err_due = e_ack && m_req && !m_we && sel == 2;
         if (e_ack && m_req && !m_we) q_dst.push_back(sel);
      end
   end

   task automatic idle();
      m_req = 0; m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0;
      s0_ack = 0; s0_resp = 0; s0_rdata = 0;
      s1_ack = 0; s1_resp = 0; s1_rdata = 0;
   endtask
   task automatic tick(); @(posedge clk); #1; endtask
   task automatic look(); @(negedge clk); #1; endtask
   task automatic rd(input logic [31:0] a);
      m_req = 1; m_we = 0; m_addr = a; m_be = 4'hF;
   endtask
   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      m_req = 1; m_we = 1; m_addr = a; m_be = be; m_wdata = d;
   endtask

   initial begin
      idle();
      rst_i = 0;
      // reset held: requests must not leak out
      rd(32'h10); s0_ack = 1; s0_resp = 1;
      look();
      chk("rst_s0_req", 32'(s0_req), 0);
      chk("rst_m_ack",  32'(m_ack),  0);
      chk("rst_m_resp", 32'(m_resp), 0);
      tick(); tick();
      rst_i = 1;

      // single RAM read, response two cycles after ack
      idle(); rd(32'h0000_0010); s0_ack = 1; look();
      chk("t1_s0_req", 32'(s0_req), 1); chk("t1_ack", 32'(m_ack), 1);
      tick(); idle(); look(); chk("t1_wait_resp", 32'(m_resp), 0);
      tick(); idle(); s0_resp = 1; s0_rdata = 32'h1234; look();
      chk("t1_resp", 32'(m_resp), 1); chk("t1_rdata", m_rdata, 32'h1234);
      tick(); idle(); s0_resp = 1; s0_rdata = 32'h5555; look();
      chk("t1_cnt0_ignore", 32'(m_resp), 0);
      tick();

      // four IO reads fill the window, fifth stalls until a response has been counted
      for (int i = 0; i < 4; i++) begin
         idle(); rd(32'h8000_0000 + 32'(4 * i)); s1_ack = 1; look();
         chk("t2_fill_ack", 32'(m_ack), 1);
         tick();
      end
      idle(); rd(32'h8000_0010); s1_ack = 1; look();
      chk("t2_full_ack", 32'(m_ack), 0); chk("t2_full_req", 32'(s1_req), 0);
      tick(); idle(); rd(32'h8000_0010); s1_ack = 1; s1_resp = 1; s1_rdata = 32'hA0; look();
      chk("t2_rsp_cycle_ack", 32'(m_ack), 0); chk("t2_rdata0", m_rdata, 32'hA0);
      tick(); idle(); rd(32'h8000_0010); s1_ack = 1; s1_resp = 1; s1_rdata = 32'hA1; look();
      chk("t2_fifth_ack", 32'(m_ack), 1); chk("t2_rdata1", m_rdata, 32'hA1);
      for (int i = 2; i < 5; i++) begin
         tick(); idle(); s1_resp = 1; s1_rdata = 32'hA0 + 32'(i); look();
         chk("t2_drain", m_rdata, 32'hA0 + 32'(i));
      end
      tick(); idle(); look(); chk("t2_empty", 32'(m_resp), 0);
      tick();

      // RAM read pending blocks IO read until one cycle after its response
      idle(); rd(32'h20); s0_ack = 1; look(); chk("t3_s0_ack", 32'(m_ack), 1);
      tick(); idle(); rd(32'h8000_0004); s1_ack = 1; look();
      chk("t3_block_ack", 32'(m_ack), 0); chk("t3_block_req", 32'(s1_req), 0);
      tick(); idle(); rd(32'h8000_0004); s1_ack = 1; s0_resp = 1; s0_rdata = 32'h55; look();
      chk("t3_s0_resp", m_rdata, 32'h55); chk("t3_still_block", 32'(s1_req), 0);
      tick(); idle(); rd(32'h8000_0004); s1_ack = 1; look();
      chk("t3_s1_req", 32'(s1_req), 1); chk("t3_s1_ack", 32'(m_ack), 1);
      tick(); idle(); wr(32'h30, 4'hF, 32'h1111_2222); s0_ack = 1; look();
      chk("t3_wr_block", 32'(m_ack), 0); chk("t3_wr_s0_req", 32'(s0_req), 0);
      tick(); idle(); s1_resp = 1; s1_rdata = 32'h77; look();
      chk("t3_s1_resp", m_rdata, 32'h77);
      tick();

      // unmapped accesses
      idle(); rd(32'h4000_0000); look();
      chk("t4_err_ack", 32'(m_ack), 1); chk("t4_no_req", 32'({s0_req, s1_req}), 0);
      tick(); idle(); wr(32'h4000_0000, 4'hF, 32'h0BAD_0BAD); look();
      chk("t4_err_resp", 32'(m_resp), 1); chk("t4_err_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("t4_wr_ack", 32'(m_ack), 1); chk("t4_wr_no_req", 32'({s0_req, s1_req}), 0);
      tick(); idle(); rd(32'h4000_0100); look();
      chk("t4_after_wr_resp", 32'(m_resp), 0); chk("t4_b2b_ack0", 32'(m_ack), 1);
      tick(); idle(); rd(32'h4000_0200); look();
      chk("t4_b2b_resp0", 32'(m_resp), 1); chk("t4_b2b_ack1", 32'(m_ack), 1);
      tick(); idle(); look(); chk("t4_b2b_resp1", m_rdata, 32'hDEAD_BEEF);
      tick(); idle(); look(); chk("t4_done", 32'(m_resp), 0);
      tick();

      // write beside pending reads, then accept and response in the same cycle
      idle(); rd(32'h100); s0_ack = 1; look(); tick();
      idle(); rd(32'h104); s0_ack = 1; look(); chk("t5_second_ack", 32'(m_ack), 1); tick();
      idle(); wr(32'h40, 4'h3, 32'hCAFE_F00D); s0_ack = 1; look();
      chk("t5_wr_ack", 32'(m_ack), 1); chk("t5_wr_we", 32'(s0_we), 1);
      chk("t5_wr_data", s0_wdata, 32'hCAFE_F00D); chk("t5_wr_be", 32'(s0_be), 32'h3);
      tick(); idle(); rd(32'h108); s0_ack = 1; s0_resp = 1; s0_rdata = 32'h1; look();
      chk("t5_same_ack", 32'(m_ack), 1); chk("t5_same_rdata", m_rdata, 32'h1);
      for (int i = 2; i <= 3; i++) begin
         tick(); idle(); s0_resp = 1; s0_rdata = 32'(i); look();
         chk("t5_order", m_rdata, 32'(i));
      end
      tick(); idle(); look(); chk("t5_empty", 32'(m_resp), 0);
      tick();

      // reset in the middle of three outstanding reads
      for (int i = 0; i < 3; i++) begin
         idle(); rd(32'h200 + 32'(4 * i)); s0_ack = 1; look(); tick();
      end
      idle(); rst_i = 0; rd(32'h20C); s0_ack = 1; s0_resp = 1; s0_rdata = 32'h66; look();
      chk("t6_rst_req", 32'(s0_req), 0); chk("t6_rst_ack", 32'(m_ack), 0);
      chk("t6_rst_resp", 32'(m_resp), 0);
      tick(); rst_i = 1;
      for (int i = 0; i < 2; i++) begin
         idle(); s0_resp = 1; s0_rdata = 32'h99; look();
         chk("t6_late_resp", 32'(m_resp), 0);
         tick();
      end
      idle(); rd(32'h210); s0_ack = 1; look();
      chk("t6_new_req", 32'(s0_req), 1); chk("t6_new_ack", 32'(m_ack), 1);
      tick(); idle(); s0_resp = 1; s0_rdata = 32'h42; look();
      chk("t6_new_resp", m_rdata, 32'h42);
      tick(); idle(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
